// File: rtl/combiner_pkg.sv
// Shared types and constants for the multi-source brightness combiner.
package combiner_pkg;

  typedef enum logic [1:0] {
    MODE_PASS    = 2'd0,
    MODE_ABSDIFF = 2'd1,
    MODE_MAX     = 2'd2,
    MODE_SUM_SAT = 2'd3
  } combine_mode_t;

  localparam int unsigned PIPE_LATENCY = 3;

endpackage

// File: rtl/brightness_reduce.sv
// Combinational reduction of NUM_SRC brightness sources to one value under the selected mode.
module brightness_reduce
  import combiner_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned BRIGHT_W = 8
) (
  input  logic [NUM_SRC*BRIGHT_W-1:0] brightness,
  input  logic [NUM_SRC-1:0]          enable,
  input  combine_mode_t               mode,
  output logic [BRIGHT_W-1:0]         reduced_c
);

  localparam int unsigned SUM_W = BRIGHT_W + $clog2(NUM_SRC);
  localparam int unsigned CNT_W = $clog2(NUM_SRC + 1);

  logic [BRIGHT_W-1:0] src;
  logic [BRIGHT_W-1:0] max_v;
  logic [BRIGHT_W-1:0] min_v;
  logic [SUM_W-1:0]    sum;
  logic [CNT_W-1:0]    cnt;

  // Gather max, min, sum and count over the enabled sources only.
  always_comb begin
    src   = '0;
    max_v = '0;
    min_v = '1;
    sum   = '0;
    cnt   = '0;
    for (int k = 0; k < NUM_SRC; k++) begin
      src = brightness[k*BRIGHT_W +: BRIGHT_W];
      if (enable[k]) begin
        if (src > max_v) max_v = src;
        if (src < min_v) min_v = src;
        sum = sum + SUM_W'(src);
        cnt = cnt + CNT_W'(1);
      end
    end
  end

  always_comb begin
    reduced_c = '0;
    case (mode)
      MODE_PASS:    reduced_c = brightness[BRIGHT_W-1:0];
      MODE_ABSDIFF: begin
        // A lone enabled source reports its own value rather than a zero spread.
        if (cnt == CNT_W'(1))      reduced_c = max_v;
        else if (cnt != CNT_W'(0)) reduced_c = max_v - min_v;
      end
      MODE_MAX:     reduced_c = max_v;
      MODE_SUM_SAT: begin
        if (sum > SUM_W'({BRIGHT_W{1'b1}})) reduced_c = '1;
        else                                reduced_c = sum[BRIGHT_W-1:0];
      end
      default:      reduced_c = '0;
    endcase
  end

endmodule

// File: rtl/multi_source_combiner.sv
// Three-stage pixel pipeline: reduce brightness sources, scale RGB by (b+1), normalise and blank.
module multi_source_combiner
  import combiner_pkg::*;
#(
  parameter int unsigned NUM_SRC  = 3,
  parameter int unsigned BRIGHT_W = 8,
  parameter int unsigned COLOR_W  = 8,
  parameter int unsigned HC_W     = 11,
  parameter int unsigned VC_W     = 10,
  parameter int unsigned H_ACTIVE = 1280,
  parameter int unsigned V_ACTIVE = 720
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [HC_W-1:0]             h_count_in,
  input  logic [VC_W-1:0]             v_count_in,
  input  logic [NUM_SRC*BRIGHT_W-1:0] brightness_in,
  input  logic [NUM_SRC-1:0]          src_enable_in,
  input  logic [1:0]                  mode_in,
  input  logic [3*COLOR_W-1:0]        pixel_color_in,
  output logic [HC_W-1:0]             h_count_out,
  output logic [VC_W-1:0]             v_count_out,
  output logic                        active_draw_out,
  output logic [3*COLOR_W-1:0]        pixel_color_out,
  output logic [1:0]                  mode_active
);

  localparam int unsigned PROD_W  = COLOR_W + BRIGHT_W + 1;
  localparam int unsigned SCALE_W = BRIGHT_W + 1;
  localparam int unsigned PIX_W   = 3 * COLOR_W;

  combine_mode_t        shadow_mode;
  logic [NUM_SRC-1:0]   shadow_en;

  logic                 frame_start_c;
  combine_mode_t        eff_mode_c;
  logic [NUM_SRC-1:0]   eff_en_c;
  logic [BRIGHT_W-1:0]  reduced_c;
  logic [SCALE_W-1:0]   scale_c;
  logic                 in_area_c;

  // Stage 3 valid is folded into active_draw_out, so only two stages are tracked here.
  logic [PIPE_LATENCY-2:0] valid;

  logic [BRIGHT_W-1:0]  s1_bright;
  logic [PIX_W-1:0]     s1_color;
  logic [HC_W-1:0]      s1_h;
  logic [VC_W-1:0]      s1_v;

  logic [PROD_W-1:0]    s2_prod [3];
  logic [HC_W-1:0]      s2_h;
  logic [VC_W-1:0]      s2_v;

  // Frame-start pixel sees the freshly requested mode/enables in the same cycle.
  always_comb begin
    frame_start_c = (h_count_in == '0) && (v_count_in == '0);
    eff_mode_c    = frame_start_c ? combine_mode_t'(mode_in) : shadow_mode;
    eff_en_c      = frame_start_c ? src_enable_in : shadow_en;
    scale_c       = SCALE_W'(s1_bright) + SCALE_W'(1);
    in_area_c     = (s2_h < HC_W'(H_ACTIVE)) && (s2_v < VC_W'(V_ACTIVE));
  end

  brightness_reduce #(
    .NUM_SRC  (NUM_SRC),
    .BRIGHT_W (BRIGHT_W)
  ) u_reduce (
    .brightness (brightness_in),
    .enable     (eff_en_c),
    .mode       (eff_mode_c),
    .reduced_c  (reduced_c)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      shadow_mode <= MODE_PASS;
      shadow_en   <= '1;
    end else if (frame_start_c) begin
      shadow_mode <= combine_mode_t'(mode_in);
      shadow_en   <= src_enable_in;
    end
  end

  assign mode_active = 2'(shadow_mode);

  always_ff @(posedge clk) begin
    if (rst) begin
      valid           <= '0;
      s1_bright       <= '0;
      s1_color        <= '0;
      s1_h            <= '0;
      s1_v            <= '0;
      s2_h            <= '0;
      s2_v            <= '0;
      h_count_out     <= '0;
      v_count_out     <= '0;
      active_draw_out <= 1'b0;
      pixel_color_out <= '0;
      for (int ch = 0; ch < 3; ch++) s2_prod[ch] <= '0;
    end else begin
      valid     <= {valid[PIPE_LATENCY-3:0], 1'b1};
      s1_bright <= reduced_c;
      s1_color  <= pixel_color_in;
      s1_h      <= h_count_in;
      s1_v      <= v_count_in;

      s2_h <= s1_h;
      s2_v <= s1_v;
      for (int ch = 0; ch < 3; ch++) begin
        s2_prod[ch] <= PROD_W'(s1_color[ch*COLOR_W +: COLOR_W]) * PROD_W'(scale_c);
      end

      h_count_out     <= s2_h;
      v_count_out     <= s2_v;
      active_draw_out <= valid[PIPE_LATENCY-2] && in_area_c;
      // Dropping the low BRIGHT_W bits maps b=max to unity gain and b=0 to black.
      for (int ch = 0; ch < 3; ch++) begin
        pixel_color_out[ch*COLOR_W +: COLOR_W] <=
          in_area_c ? s2_prod[ch][BRIGHT_W +: COLOR_W] : '0;
      end
    end
  end

endmodule

// File: tb/tb_multi_source_combiner.sv
// Directed self-checking bench for multi_source_combiner with hand-computed expectations.
module tb_multi_source_combiner;

  logic        clk;
  logic        rst;
  logic [10:0] h_count_in;
  logic [9:0]  v_count_in;
  logic [23:0] brightness_in;
  logic [2:0]  src_enable_in;
  logic [1:0]  mode_in;
  logic [23:0] pixel_color_in;
  logic [10:0] h_count_out;
  logic [9:0]  v_count_out;
  logic        active_draw_out;
  logic [23:0] pixel_color_out;
  logic [1:0]  mode_active;

  int checks = 0;
  int errors = 0;

  multi_source_combiner dut (
    .clk             (clk),
    .rst             (rst),
    .h_count_in      (h_count_in),
    .v_count_in      (v_count_in),
    .brightness_in   (brightness_in),
    .src_enable_in   (src_enable_in),
    .mode_in         (mode_in),
    .pixel_color_in  (pixel_color_in),
    .h_count_out     (h_count_out),
    .v_count_out     (v_count_out),
    .active_draw_out (active_draw_out),
    .pixel_color_out (pixel_color_out),
    .mode_active     (mode_active)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input int h, input int v, input logic [7:0] b2, input logic [7:0] b1,
                       input logic [7:0] b0, input logic [2:0] en, input logic [1:0] mode,
                       input logic [23:0] color);
    h_count_in     = 11'(h);
    v_count_in     = 10'(v);
    brightness_in  = {b2, b1, b0};
    src_enable_in  = en;
    mode_in        = mode;
    pixel_color_in = color;
  endtask

  task automatic hold3();
    tick(); tick(); tick();
  endtask

  task automatic test_reset();
    rst = 1'b1;
    drive(0, 0, 8'd0, 8'd0, 8'd255, 3'b111, 2'd0, 24'h123456);
    tick(); tick();
    checks++;
    if (pixel_color_out !== 24'h0 || active_draw_out !== 1'b0 || h_count_out !== 11'd0 ||
        v_count_out !== 10'd0 || mode_active !== 2'd0) begin
      errors++;
      $display("FAIL reset_state: color=%h active=%b h=%0d v=%0d mode=%0d want all 0",
               pixel_color_out, active_draw_out, h_count_out, v_count_out, mode_active);
    end
    rst = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(i, 0, 8'd0, 8'd0, 8'd255, 3'b111, 2'd0, 24'h123456);
      tick();
      checks++;
      if (i < 2) begin
        if (active_draw_out !== 1'b0) begin
          errors++;
          $display("FAIL reset_fill_%0d: active=%b want 0", i, active_draw_out);
        end
      end else begin
        if (active_draw_out !== 1'b1 || h_count_out !== 11'(i - 2) || v_count_out !== 10'd0 ||
            pixel_color_out !== 24'h123456) begin
          errors++;
          $display("FAIL reset_stream_%0d: active=%b h=%0d v=%0d color=%h want 1 %0d 0 123456",
                   i, active_draw_out, h_count_out, v_count_out, pixel_color_out, i - 2);
        end
      end
    end
  endtask

  task automatic test_pass();
    drive(0, 0, 8'd0, 8'd0, 8'd255, 3'b111, 2'd0, 24'h80C0FF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h80C0FF || mode_active !== 2'd0 || active_draw_out !== 1'b1) begin
      errors++;
      $display("FAIL pass_full: color=%h mode=%0d active=%b want 80c0ff 0 1",
               pixel_color_out, mode_active, active_draw_out);
    end
    drive(10, 10, 8'd99, 8'd99, 8'd0, 3'b000, 2'd3, 24'h80C0FF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h000000 || mode_active !== 2'd0) begin
      errors++;
      $display("FAIL pass_zero: color=%h mode=%0d want 000000 0", pixel_color_out, mode_active);
    end
    drive(10, 10, 8'd0, 8'd0, 8'd128, 3'b111, 2'd0, 24'hFFC000);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h806000) begin
      errors++;
      $display("FAIL pass_half: color=%h want 806000", pixel_color_out);
    end
  endtask

  task automatic test_absdiff();
    drive(0, 0, 8'd10, 8'd50, 8'd200, 3'b011, 2'd1, 24'hFF0000);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h960000 || mode_active !== 2'd1) begin
      errors++;
      $display("FAIL absdiff_two: color=%h mode=%0d want 960000 1", pixel_color_out, mode_active);
    end
    drive(0, 0, 8'd10, 8'd50, 8'd200, 3'b001, 2'd1, 24'hFF0000);
    hold3();
    checks++;
    if (pixel_color_out !== 24'hC80000) begin
      errors++;
      $display("FAIL absdiff_single: color=%h want c80000", pixel_color_out);
    end
  endtask

  task automatic test_sum_max();
    drive(0, 0, 8'd10, 8'd100, 8'd200, 3'b111, 2'd3, 24'h80C0FF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h80C0FF || mode_active !== 2'd3) begin
      errors++;
      $display("FAIL sum_clamp: color=%h mode=%0d want 80c0ff 3", pixel_color_out, mode_active);
    end
    drive(5, 5, 8'd30, 8'd20, 8'd10, 3'b000, 2'd0, 24'hFF00FF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h3C003C) begin
      errors++;
      $display("FAIL sum_plain: color=%h want 3c003c", pixel_color_out);
    end
    drive(0, 0, 8'd10, 8'd50, 8'd200, 3'b000, 2'd2, 24'hFFFFFF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h000000 || mode_active !== 2'd2) begin
      errors++;
      $display("FAIL max_none: color=%h mode=%0d want 000000 2", pixel_color_out, mode_active);
    end
    drive(0, 0, 8'd10, 8'd50, 8'd200, 3'b110, 2'd2, 24'h0000FF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h000032) begin
      errors++;
      $display("FAIL max_partial: color=%h want 000032", pixel_color_out);
    end
  endtask

  task automatic test_midframe();
    drive(0, 0, 8'd10, 8'd200, 8'd40, 3'b111, 2'd2, 24'h0000FF);
    hold3();
    drive(640, 360, 8'd10, 8'd200, 8'd40, 3'b001, 2'd0, 24'h0000FF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h0000C8 || mode_active !== 2'd2) begin
      errors++;
      $display("FAIL midframe_ignored: color=%h mode=%0d want 0000c8 2",
               pixel_color_out, mode_active);
    end
    drive(0, 0, 8'd10, 8'd200, 8'd40, 3'b111, 2'd0, 24'h0000FF);
    tick();
    checks++;
    if (mode_active !== 2'd0) begin
      errors++;
      $display("FAIL midframe_latch_delay: mode=%0d want 0", mode_active);
    end
    tick(); tick();
    checks++;
    if (pixel_color_out !== 24'h000028) begin
      errors++;
      $display("FAIL midframe_new_mode: color=%h want 000028", pixel_color_out);
    end
  endtask

  task automatic test_outside();
    drive(1280, 100, 8'd0, 8'd0, 8'd255, 3'b111, 2'd0, 24'hFFFFFF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h0 || active_draw_out !== 1'b0 || h_count_out !== 11'd1280 ||
        v_count_out !== 10'd100) begin
      errors++;
      $display("FAIL outside_h: color=%h active=%b h=%0d v=%0d want 0 0 1280 100",
               pixel_color_out, active_draw_out, h_count_out, v_count_out);
    end
    drive(1279, 720, 8'd0, 8'd0, 8'd255, 3'b111, 2'd0, 24'hFFFFFF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'h0 || active_draw_out !== 1'b0) begin
      errors++;
      $display("FAIL outside_v: color=%h active=%b want 0 0", pixel_color_out, active_draw_out);
    end
    drive(1279, 719, 8'd0, 8'd0, 8'd255, 3'b111, 2'd0, 24'hFFFFFF);
    hold3();
    checks++;
    if (pixel_color_out !== 24'hFFFFFF || active_draw_out !== 1'b1) begin
      errors++;
      $display("FAIL inside_corner: color=%h active=%b want ffffff 1",
               pixel_color_out, active_draw_out);
    end
  endtask

  task automatic test_back_to_back();
    logic [7:0]  bv  [4];
    logic [23:0] col [4];
    logic [23:0] exp_col [4];
    bv[0] = 8'd255; col[0] = 24'h102030; exp_col[0] = 24'h102030;
    bv[1] = 8'd0;   col[1] = 24'hFFFFFF; exp_col[1] = 24'h000000;
    bv[2] = 8'd128; col[2] = 24'hFFFFFF; exp_col[2] = 24'h808080;
    bv[3] = 8'd255; col[3] = 24'hABCDEF; exp_col[3] = 24'hABCDEF;
    for (int i = 0; i < 6; i++) begin
      if (i < 4) drive(20 + i, 1, 8'd0, 8'd0, bv[i], 3'b111, 2'd0, col[i]);
      tick();
      if (i >= 2) begin
        checks++;
        if (pixel_color_out !== exp_col[i-2] || h_count_out !== 11'(18 + i) ||
            v_count_out !== 10'd1 || active_draw_out !== 1'b1) begin
          errors++;
          $display("FAIL b2b_%0d: color=%h h=%0d v=%0d active=%b want %h %0d 1 1", i - 2,
                   pixel_color_out, h_count_out, v_count_out, active_draw_out,
                   exp_col[i-2], 18 + i);
        end
      end
    end
  endtask

  task automatic test_reset_midline();
    drive(0, 0, 8'd10, 8'd50, 8'd200, 3'b111, 2'd2, 24'hFFFFFF);
    hold3();
    drive(100, 5, 8'd10, 8'd50, 8'd200, 3'b111, 2'd0, 24'hFFFFFF);
    tick();
    rst = 1'b1;
    tick();
    checks++;
    if (pixel_color_out !== 24'h0 || active_draw_out !== 1'b0 || h_count_out !== 11'd0 ||
        v_count_out !== 10'd0 || mode_active !== 2'd0) begin
      errors++;
      $display("FAIL reset_midline: color=%h active=%b h=%0d v=%0d mode=%0d want all 0",
               pixel_color_out, active_draw_out, h_count_out, v_count_out, mode_active);
    end
    rst = 1'b0;
    tick(); tick();
    checks++;
    if (active_draw_out !== 1'b0 || mode_active !== 2'd0) begin
      errors++;
      $display("FAIL reset_refill: active=%b mode=%0d want 0 0", active_draw_out, mode_active);
    end
  endtask

  initial begin
    rst = 1'b1;
    drive(0, 0, 8'd0, 8'd0, 8'd0, 3'b111, 2'd0, 24'h0);
    test_reset();
    test_pass();
    test_absdiff();
    test_sum_max();
    test_midframe();
    test_outside();
    test_back_to_back();
    test_reset_midline();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/multi_source_combiner.md
Name: multi_source_combiner

Overview:
- Parametrised successor to the video base combiner: reduces NUM_SRC brightness streams to one brightness value using a selectable mode, then scales each RGB channel of the incoming pixel by that brightness with real multipliers.
- Sits between the per-source brightness generators and the HDMI output stage, in the pixel clock domain.
- Delays h/v counts to stay aligned with the 3-cycle pixel pipeline.
- Latches mode and source enables at frame start, so a mid-frame mode change cannot tear the image.

Parameters:
- NUM_SRC, 3: number of brightness sources; legal range 2..8.
- BRIGHT_W, 8: width of each brightness value.
- COLOR_W, 8: width of each colour channel.
- HC_W, 11: h_count width.
- VC_W, 10: v_count width.
- H_ACTIVE, 1280: active pixels per line.
- V_ACTIVE, 720: active lines per frame.

Ports:
- clk  in  1: pixel clock.
- rst  in  1: synchronous, active-high reset.
- h_count_in  in  HC_W: horizontal position of the input pixel.
- v_count_in  in  VC_W: vertical position of the input pixel.
- brightness_in  in  NUM_SRC*BRIGHT_W: packed sources; source k occupies bits [k*BRIGHT_W +: BRIGHT_W].
- src_enable_in  in  NUM_SRC: per-source enable request.
- mode_in  in  2: requested combine mode (combine_mode_t).
- pixel_color_in  in  3*COLOR_W: {R,G,B} base colour.
- h_count_out  out  HC_W: h_count delayed 3 cycles.
- v_count_out  out  VC_W: v_count delayed 3 cycles.
- active_draw_out  out  1: output pixel is valid and inside the active area.
- pixel_color_out  out  3*COLOR_W: scaled {R,G,B}.
- mode_active  out  2: mode currently in effect (shadow register).

Behaviour:
- Clock and reset: one clock (clk); reset is synchronous and active-high (rst).
- Reset values:
  - All pipeline registers and outputs go to 0.
  - Shadow mode goes to MODE_PASS; shadow enable goes to all ones.
  - 3-bit valid shift register is cleared, so active_draw_out stays 0 for the first 3 cycles after reset deasserts.
- Frame-start latch:
  - On any cycle with h_count_in==0 and v_count_in==0, the shadow registers capture mode_in and src_enable_in.
  - Stage 1 for that same pixel uses the newly captured values (bypass).
  - At all other times mode_in and src_enable_in are ignored.
- Stage 1 (reduce), registered; brightness is b, disabled sources are excluded:
  - MODE_PASS (0): b = source 0, regardless of enables.
  - MODE_ABSDIFF (1): b = max - min over enabled sources. With exactly one source enabled, b = that source's value. With none enabled, b = 0.
  - MODE_MAX (2): b = maximum over enabled sources; 0 if none enabled.
  - MODE_SUM_SAT (3): sum of enabled sources in BRIGHT_W+$clog2(NUM_SRC) bits, clamped to 2^BRIGHT_W-1.
  - Stage 1 also registers pixel colour, counts, and valid.
- Stage 2 (multiply), registered: per channel, p = c * (b + 1). Width is COLOR_W+BRIGHT_W+1, unsigned, no truncation before the shift.
- Stage 3 (normalise), registered:
  - out = p >> BRIGHT_W, so b = max gives out = c and b = 0 gives out = 0.
  - If the delayed counts fall outside the active area (h >= H_ACTIVE or v >= V_ACTIVE), pixel_color_out is forced to 0.
- Latency: exactly 3 cycles from input to all outputs; throughput is 1 pixel per cycle with no stalls.
- active_draw_out = valid[2] && h_count_out < H_ACTIVE && v_count_out < V_ACTIVE.
- mode_active reflects the shadow register immediately after capture (1 cycle after the frame-start input).
- Reset mid-frame: the pipeline is flushed to 0 and the shadow returns to reset values. The next frame start re-latches.
- Counts are passed through unmodified; the block never checks count wrap.

Decomposition:
- Shared package combiner_pkg:
  - typedef enum logic [1:0] combine_mode_t {MODE_PASS, MODE_ABSDIFF, MODE_MAX, MODE_SUM_SAT}.
  - localparam PIPE_LATENCY = 3.
- One sub-module, brightness_reduce:
  - Parametrised on NUM_SRC and BRIGHT_W.
  - Takes the packed sources, the enables and the mode, and produces the unregistered reduced brightness.
- The top level owns the shadow registers, the pipeline registers and the multipliers.

Test Plan:
- Reset, then stream counts (0,0),(1,0),… → active_draw_out stays 0 for 3 cycles; h_count_out==0 and v_count_out==0 appear on cycle 3 with active 1.
- MODE_PASS latched, b0=255, colour 0x80C0FF → output 0x80C0FF after 3 cycles; b0=0 → 0x000000; b0=128, R=0xFF → R_out = (255*129)>>8 = 0x80.
- MODE_ABSDIFF, enables 011, b0=200, b1=50 → b=150; colour 0xFF0000 → 0x960000. With enables 001 → b=200.
- MODE_SUM_SAT, enables 111, sources 200/100/10 → clamp to 255, colour unchanged. MODE_MAX with enables 000 → 0x000000.
- Change mode_in mid-frame at (640,360) → mode_active and the output are unchanged until input (0,0), where the new mode applies to that pixel.
- Input h=1280, v=100, colour 0xFFFFFF, b=255 → pixel_color_out 0, active_draw_out 0. Assert rst mid-line → all outputs 0 on the next cycle.
